// File: rtl/aclk_pkg.sv
// -----------------------------------------------------------------------------
// aclk_pkg
// Shared definitions for the alarm/clock keypad entry path.
//   DIGIT_W_DEFAULT : default digit width (BCD)
//   BCD_MAX, HR_MS_MAX, HR_LS_MAX_AT_20, MIN_MS_MAX : 24-hour HH:MM digit limits
//   event_t / pick_event : one-event-per-cycle priority encoding
//                          (clear > backspace > load_req > key_valid)
// -----------------------------------------------------------------------------
package aclk_pkg;

    localparam int DIGIT_W_DEFAULT = 4;

    localparam int BCD_MAX         = 9;
    localparam int HR_MS_MAX       = 2;
    localparam int HR_LS_MAX_AT_20 = 3;
    localparam int MIN_MS_MAX      = 5;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_CLEAR = 3'd1,
        EV_BKSP  = 3'd2,
        EV_LOAD  = 3'd3,
        EV_KEY   = 3'd4
    } event_t;

    // Picks the single strobe that acts this cycle; the rest are dropped.
    function automatic event_t pick_event(input logic clr,
                                          input logic bksp,
                                          input logic load,
                                          input logic key_v);
        if (clr)   return EV_CLEAR;
        if (bksp)  return EV_BKSP;
        if (load)  return EV_LOAD;
        if (key_v) return EV_KEY;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/aclk_idle_timer.sv
// -----------------------------------------------------------------------------
// aclk_idle_timer
// Idle counter for a partially entered value.
//   clock, reset : clock and asynchronous active-high reset
//   restart      : zero the counter this edge (a user event or an auto-clear)
//   enable       : counting allowed (entry non-empty); held at zero otherwise
//   expire       : counter sits at TIMEOUT_CYC-1 while enabled, so the next
//                  edge should auto-clear the entry
// TIMEOUT_CYC = 0 removes the counter and expire is constant 0.
// -----------------------------------------------------------------------------
module aclk_idle_timer #(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (restart || !enable) begin
                    cnt_q <= '0;
                end else if (cnt_q != LAST) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign expire = enable && (cnt_q == LAST);
        end else begin : g_no_timer
            logic unused_inputs;
            assign unused_inputs = restart ^ enable ^ clock ^ reset;
            assign expire        = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/aclk_keybuf.sv
// -----------------------------------------------------------------------------
// aclk_keybuf
// Key-entry buffer between the keypad FSM and the alarm/time registers.
// Holds the last N_DIGITS accepted digits (slot 0 = newest / ls_min).
//   clock, reset   : clock and asynchronous active-high reset
//   key_valid, key : keypress strobe and value (values > 9 are rejected)
//   backspace      : drop the newest digit
//   clear          : empty the buffer
//   load_req       : commit request; accepted only when full and time_ok
//   digits         : slot i at bits [i*DIGIT_W +: DIGIT_W]
//   count, full    : digits entered / count == N_DIGITS
//   time_ok        : digits form a legal 24-hour HH:MM (or constant 1)
//   load_pulse, load_err, reject, timeout_pulse : registered one-cycle pulses
// -----------------------------------------------------------------------------
module aclk_keybuf
    import aclk_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_W     = DIGIT_W_DEFAULT,
    parameter int TIMEOUT_CYC = 0,
    parameter int CHECK_TIME  = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            key_valid,
    input  logic [DIGIT_W-1:0]              key,
    input  logic                            backspace,
    input  logic                            clear,
    input  logic                            load_req,
    output logic [N_DIGITS*DIGIT_W-1:0]     digits,
    output logic [$clog2(N_DIGITS+1)-1:0]   count,
    output logic                            full,
    output logic                            time_ok,
    output logic                            load_pulse,
    output logic                            load_err,
    output logic                            reject,
    output logic                            timeout_pulse
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DIGITS);

    logic [DIGIT_W-1:0] slot_q [N_DIGITS];
    logic [DIGIT_W-1:0] slot_d [N_DIGITS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               load_pulse_d, load_err_d, reject_d, timeout_d;
    logic               key_bad;
    logic               expire;
    event_t             ev;

    assign ev      = pick_event(clear, backspace, load_req, key_valid);
    assign key_bad = key > DIGIT_W'(BCD_MAX);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;

    // Any acting event (even a refused load or rejected key) restarts the
    // idle count; an auto-clear restarts it too.
    aclk_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .restart ((ev != EV_NONE) || expire),
        .enable  (count_q != '0),
        .expire  (expire)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        slot_d       = slot_q;
        count_d      = count_q;
        load_pulse_d = 1'b0;
        load_err_d   = 1'b0;
        reject_d     = 1'b0;
        timeout_d    = 1'b0;
        case (ev)
            EV_CLEAR: begin
                for (int i = 0; i < N_DIGITS; i++) slot_d[i] = '0;
                count_d = '0;
            end
            EV_BKSP: begin
                if (count_q != '0) begin
                    for (int i = 0; i < N_DIGITS - 1; i++) slot_d[i] = slot_q[i+1];
                    slot_d[N_DIGITS-1] = '0;
                    count_d            = count_q - CNT_W'(1);
                end
            end
            EV_LOAD: begin
                // Digits are held so the consumer samples them with load_pulse.
                if (full && time_ok) begin
                    load_pulse_d = 1'b1;
                    count_d      = '0;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            EV_KEY: begin
                if (key_bad) begin
                    reject_d = 1'b1;
                end else begin
                    for (int i = 1; i < N_DIGITS; i++) slot_d[i] = slot_q[i-1];
                    slot_d[0] = key;
                    if (!full) count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                // A user event in the same cycle always wins over the timeout.
                if (expire) begin
                    for (int i = 0; i < N_DIGITS; i++) slot_d[i] = '0;
                    count_d   = '0;
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the slot array is a handful of flops, not a RAM, and its
            // reset value is architecturally visible, so it is reset here.
            slot_q        <= '{default: '0};
            count_q       <= '0;
            load_pulse    <= 1'b0;
            load_err      <= 1'b0;
            reject        <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            slot_q        <= slot_d;
            count_q       <= count_d;
            load_pulse    <= load_pulse_d;
            load_err      <= load_err_d;
            reject        <= reject_d;
            timeout_pulse <= timeout_d;
        end
    end

    always_comb begin
        digits = '0;
        for (int i = 0; i < N_DIGITS; i++) digits[i*DIGIT_W +: DIGIT_W] = slot_q[i];
    end

    generate
        if (CHECK_TIME == 1 && N_DIGITS == 4) begin : g_time_check
            // slot 3 = ms_hr, 2 = ls_hr, 1 = ms_min, 0 = ls_min
            assign time_ok = (slot_q[3] <= DIGIT_W'(HR_MS_MAX))
                          && (slot_q[2] <= DIGIT_W'(BCD_MAX))
                          && ((slot_q[3] != DIGIT_W'(HR_MS_MAX))
                              || (slot_q[2] <= DIGIT_W'(HR_LS_MAX_AT_20)))
                          && (slot_q[1] <= DIGIT_W'(MIN_MS_MAX))
                          && (slot_q[0] <= DIGIT_W'(BCD_MAX));
        end else begin : g_no_time_check
            assign time_ok = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_aclk_keybuf.sv
// -----------------------------------------------------------------------------
// tb_aclk_keybuf
// Self-checking bench for aclk_keybuf (N_DIGITS=4, DIGIT_W=4, TIMEOUT_CYC=8).
// The reference keeps the entry as a queue of four digits (index 0 = newest)
// plus an entered-digit count and an idle-cycle count, and judges the time
// value as an hour/minute number.
// -----------------------------------------------------------------------------
module tb_aclk_keybuf;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid, backspace, clear, load_req;
    logic [3:0]  key;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full, time_ok, load_pulse, load_err, reject, timeout_pulse;

    aclk_keybuf #(
        .N_DIGITS    (4),
        .DIGIT_W     (4),
        .TIMEOUT_CYC (TO),
        .CHECK_TIME  (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key           (key),
        .backspace     (backspace),
        .clear         (clear),
        .load_req      (load_req),
        .digits        (digits),
        .count         (count),
        .full          (full),
        .time_ok       (time_ok),
        .load_pulse    (load_pulse),
        .load_err      (load_err),
        .reject        (reject),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference state
    int q[$];
    int m_cnt, m_idle;
    bit e_lp, e_le, e_rej, e_to;

    function automatic logic [15:0] m_digits();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) v = v | (16'(q[i] & 15) << (4 * i));
        return v;
    endfunction

    function automatic bit m_time_ok();
        int hh = q[3] * 10 + q[2];
        return (q[3] <= 2) && (q[2] <= 9) && (hh <= 23) && (q[1] <= 5) && (q[0] <= 9);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"},  32'(digits),        32'(m_digits()));
        check({tag, ".count"},   32'(count),         32'(m_cnt));
        check({tag, ".full"},    32'(full),          32'(m_cnt == 4));
        check({tag, ".time_ok"}, 32'(time_ok),       32'(m_time_ok()));
        check({tag, ".load_p"},  32'(load_pulse),    32'(e_lp));
        check({tag, ".load_e"},  32'(load_err),      32'(e_le));
        check({tag, ".reject"},  32'(reject),        32'(e_rej));
        check({tag, ".timeout"}, 32'(timeout_pulse), 32'(e_to));
    endtask

    task automatic model_reset();
        q      = {0, 0, 0, 0};
        m_cnt  = 0;
        m_idle = 0;
        e_lp   = 0;
        e_le   = 0;
        e_rej  = 0;
        e_to   = 0;
    endtask

    // One clock of stimulus: drive at negedge, update the reference, check
    // just after the following posedge.
    task automatic step(input bit c, input bit b, input bit l, input bit kv,
                        input logic [3:0] k, input string tag);
        @(negedge clock);
        clear     = c;
        backspace = b;
        load_req  = l;
        key_valid = kv;
        key       = k;
        e_lp = 0; e_le = 0; e_rej = 0; e_to = 0;
        if (c) begin
            q = {0, 0, 0, 0};
            m_cnt  = 0;
            m_idle = 0;
        end else if (b) begin
            if (m_cnt > 0) begin
                void'(q.pop_front());
                q.push_back(0);
                m_cnt--;
            end
            m_idle = 0;
        end else if (l) begin
            if (m_cnt == 4 && m_time_ok()) begin
                e_lp  = 1;
                m_cnt = 0;
            end else begin
                e_le = 1;
            end
            m_idle = 0;
        end else if (kv) begin
            if (k > 9) begin
                e_rej = 1;
            end else begin
                q.push_front(int'(k));
                void'(q.pop_back());
                if (m_cnt < 4) m_cnt++;
            end
            m_idle = 0;
        end else begin
            if (m_cnt > 0 && m_idle == TO - 1) begin
                q = {0, 0, 0, 0};
                m_cnt  = 0;
                m_idle = 0;
                e_to   = 1;
            end else if (m_cnt == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic key_in(input logic [3:0] k, input string tag);
        step(0, 0, 0, 1, k, tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 4'h0, tag);
    endtask

    // Reset raised between edges: outputs must drop before the next posedge.
    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".digits"},  32'(digits),        32'h0);
        check({tag, ".count"},   32'(count),         32'h0);
        check({tag, ".full"},    32'(full),          32'h0);
        check({tag, ".load_p"},  32'(load_pulse),    32'h0);
        check({tag, ".load_e"},  32'(load_err),      32'h0);
        check({tag, ".reject"},  32'(reject),        32'h0);
        check({tag, ".timeout"}, 32'(timeout_pulse), 32'h0);
        check({tag, ".time_ok"}, 32'(time_ok),       32'(m_time_ok()));
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        backspace = 1'b0;
        clear     = 1'b0;
        load_req  = 1'b0;
        key       = 4'h0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: valid time and commit
        key_in(4'd1, "t1.k1");
        key_in(4'd2, "t1.k2");
        key_in(4'd3, "t1.k3");
        key_in(4'd4, "t1.k4");
        step(0, 0, 1, 0, 4'h0, "t1.load");
        idle("t1.after");

        // 2: out-of-range hour refused, then overflow drops the oldest digit
        step(1, 0, 0, 0, 4'h0, "t2.clr");
        key_in(4'd2, "t2.k2");
        key_in(4'd5, "t2.k5");
        key_in(4'd0, "t2.k0a");
        key_in(4'd0, "t2.k0b");
        step(0, 0, 1, 0, 4'h0, "t2.load");
        key_in(4'd7, "t2.k7");
        step(0, 0, 1, 0, 4'h0, "t2.load2");
        step(0, 0, 1, 0, 4'h0, "t2.load3");

        // boundary: 23:59 accepted, 24:00 refused
        key_in(4'd2, "hr.a2");
        key_in(4'd3, "hr.a3");
        key_in(4'd5, "hr.a5");
        key_in(4'd9, "hr.a9");
        step(0, 0, 1, 0, 4'h0, "hr.load_ok");
        key_in(4'd2, "hr.b2");
        key_in(4'd4, "hr.b4");
        key_in(4'd0, "hr.b0a");
        key_in(4'd0, "hr.b0b");
        step(0, 0, 1, 0, 4'h0, "hr.load_bad");

        // 3: backspace, including below empty
        step(1, 0, 0, 0, 4'h0, "t3.clr");
        key_in(4'd1, "t3.k1");
        key_in(4'd2, "t3.k2");
        key_in(4'd3, "t3.k3");
        step(0, 1, 0, 0, 4'h0, "t3.bs1");
        step(0, 1, 0, 0, 4'h0, "t3.bs2");
        step(0, 1, 0, 0, 4'h0, "t3.bs3");
        step(0, 1, 0, 0, 4'h0, "t3.bs4");

        // 4: reject, back-to-back rejects, and clear beating key_valid
        key_in(4'd6, "t4.k6");
        key_in(4'hB, "t4.kB");
        key_in(4'hF, "t4.kF");
        step(1, 0, 0, 1, 4'd5, "t4.clr_key");
        step(0, 1, 1, 1, 4'hC, "t4.bs_wins");

        // 5: idle timeout, then a key on the expiry cycle
        key_in(4'd3, "t5.k3");
        for (int i = 0; i < TO; i++) idle("t5.idle");
        key_in(4'd3, "t5.k3b");
        for (int i = 0; i < TO - 1; i++) idle("t5.idle_b");
        key_in(4'd4, "t5.k_on_expiry");
        for (int i = 0; i < TO; i++) idle("t5.idle_c");

        // 6: asynchronous reset mid-entry with a pulse pending
        key_in(4'd1, "t6.k1");
        key_in(4'd2, "t6.k2");
        key_in(4'd3, "t6.k3");
        key_in(4'hA, "t6.kA");
        async_reset_check("t6.rst_reject");
        key_in(4'd1, "t6.m1");
        key_in(4'd2, "t6.m2");
        key_in(4'd3, "t6.m3");
        key_in(4'd4, "t6.m4");
        step(0, 0, 1, 0, 4'h0, "t6.load");
        async_reset_check("t6.rst_load");

        // Randomized traffic against the reference
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (n % 100 == 50) begin
                for (int i = 0; i < 10; i++) idle("rnd.burst");
            end else if (r < 30) begin
                idle("rnd.idle");
            end else if (r < 65) begin
                key_in(4'($urandom_range(0, 11)), "rnd.key");
            end else if (r < 75) begin
                step(0, 1, 0, 0, 4'h0, "rnd.bs");
            end else if (r < 85) begin
                step(0, 0, 1, 0, 4'h0, "rnd.load");
            end else if (r < 90) begin
                step(1, 0, 0, 0, 4'h0, "rnd.clr");
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), "rnd.mix");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
